// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the MNIST inference controller.
//   sched_state_t   : scheduler state encoding (IDLE, LOAD, WAIT_RESULT)
//   NN_DATAWIDTH    : default pixel width
//   NN_NUM_PIXELS   : default pixels per image (layer-1 input count)
//   NN_RESULT_WIDTH : default max-finder result width
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD        = 2'd1,
        WAIT_RESULT = 2'd2
    } sched_state_t;

    localparam int NN_DATAWIDTH    = 16;
    localparam int NN_NUM_PIXELS   = 784;
    localparam int NN_RESULT_WIDTH = 32;

endpackage : nn_pkg

// File: rtl/nn_inference_scheduler.sv
// -----------------------------------------------------------------------------
// nn_inference_scheduler
// Sequences one MNIST inference at a time: admits exactly NUM_PIXELS pixels
// from AXI-Stream into layer 1, then blocks input until the max-finder
// returns a class. Latches the result, raises a sticky irq and keeps status.
//
// Ports
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   soft_reset                : synchronous reset, highest priority
//   enable                    : level, permits starting new images
//   s_axis_tvalid/tdata/tready: pixel input stream
//   pix_valid, pix_data       : registered pixel strobe to layer 1
//   result_valid, result_class: max-finder result
//   irq_clear                 : pulse, clears irq (a same-cycle set wins)
//   irq                       : sticky completion / timeout interrupt
//   busy                      : registered, high in LOAD or WAIT_RESULT
//   last_class                : last captured result
//   image_count               : completed images, wraps
//   timeout_err               : sticky watchdog flag
//
// Build option
//   INFER_TIMEOUT_EN : when defined, a watchdog in WAIT_RESULT returns to
//                      IDLE after TIMEOUT_CYCLES cycles without a result and
//                      flags timeout_err/irq. When undefined, no counter is
//                      built and timeout_err is tied low.
// -----------------------------------------------------------------------------
module nn_inference_scheduler
    import nn_pkg::*;
#(
    parameter int DATAWIDTH      = NN_DATAWIDTH,
    parameter int NUM_PIXELS     = NN_NUM_PIXELS,
    parameter int RESULT_WIDTH   = NN_RESULT_WIDTH,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    soft_reset,
    input  logic                    enable,
    input  logic                    s_axis_tvalid,
    input  logic [DATAWIDTH-1:0]    s_axis_tdata,
    output logic                    s_axis_tready,
    output logic                    pix_valid,
    output logic [DATAWIDTH-1:0]    pix_data,
    input  logic                    result_valid,
    input  logic [RESULT_WIDTH-1:0] result_class,
    input  logic                    irq_clear,
    output logic                    irq,
    output logic                    busy,
    output logic [RESULT_WIDTH-1:0] last_class,
    output logic [COUNT_WIDTH-1:0]  image_count,
    output logic                    timeout_err
);

    localparam int                CNT_W    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NUM_PIXELS - 1);

    sched_state_t            r_state;
    sched_state_t            w_state_next;
    logic                    w_tready;
    logic                    w_beat;      // accepted pixel this cycle
    logic                    w_result;    // result captured this cycle
    logic                    w_timeout;   // watchdog limit reached
    logic                    w_to_fire;   // limit reached and no result
    logic [CNT_W-1:0]        r_pix_cnt;
    logic                    r_pix_valid;
    logic [DATAWIDTH-1:0]    r_pix_data;
    logic                    r_irq;
    logic                    r_busy;
    logic [RESULT_WIDTH-1:0] r_last_class;
    logic [COUNT_WIDTH-1:0]  r_image_count;

    // State register
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= IDLE;
        end else if (soft_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle strobes. tready is decoded from r_state only,
    // so there is no combinational path from tvalid to tready.
    always_comb begin
        w_state_next = r_state;
        w_tready     = 1'b0;
        w_beat       = 1'b0;
        w_result     = 1'b0;
        w_to_fire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = LOAD;
            end
            LOAD: begin
                w_tready = 1'b1;
                w_beat   = s_axis_tvalid;
                if (s_axis_tvalid && (r_pix_cnt == LAST_PIX)) begin
                    w_state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                // A result arriving on the watchdog limit cycle wins.
                if (result_valid) begin
                    w_result     = 1'b1;
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_to_fire    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_pix_cnt     <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_irq         <= 1'b0;
            r_busy        <= 1'b0;
            r_last_class  <= '0;
            r_image_count <= '0;
        end else if (soft_reset) begin
            r_pix_cnt     <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_irq         <= 1'b0;
            r_busy        <= 1'b0;
            r_last_class  <= '0;
            r_image_count <= '0;
        end else begin
            r_busy      <= (w_state_next != IDLE);
            r_pix_valid <= w_beat;
            if (w_beat) r_pix_data <= s_axis_tdata;

            if (r_state != LOAD) begin
                r_pix_cnt <= '0;
            end else if (w_beat) begin
                r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
            end

            if (w_result) begin
                r_last_class  <= result_class;
                r_image_count <= r_image_count + 1'b1;
            end

            // Setting has priority over a coincident clear.
            if (w_result || w_to_fire) begin
                r_irq <= 1'b1;
            end else if (irq_clear) begin
                r_irq <= 1'b0;
            end
        end
    end

`ifdef INFER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // Counter idles at zero outside WAIT_RESULT, so it restarts on every entry.
    assign w_timeout = (r_state == WAIT_RESULT) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (soft_reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != WAIT_RESULT) begin
                r_to_cnt <= '0;
            end else if (!w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_fire) r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign s_axis_tready = w_tready;
    assign pix_valid     = r_pix_valid;
    assign pix_data      = r_pix_data;
    assign irq           = r_irq;
    assign busy          = r_busy;
    assign last_class    = r_last_class;
    assign image_count   = r_image_count;

endmodule : nn_inference_scheduler

// File: doc/nn_inference_scheduler.md
# nn_inference_scheduler

Controller that sequences one MNIST inference at a time through the layer pipeline. Sits between the AXI-Stream pixel input and layer 1, and between the max-finder and the AXI-Lite register block. Admits exactly NUM_PIXELS pixels per image and blocks further input until the classification result returns. Latches the result, raises a sticky interrupt, and reports busy, image-count and timeout status.

## Interface
- DATAWIDTH, 16, pixel width
- NUM_PIXELS, 784, pixels per image (layer-1 input count)
- RESULT_WIDTH, 32, max-finder result width
- COUNT_WIDTH, 16, completed-image counter width
- TIMEOUT_CYCLES, 65535, watchdog limit in WAIT_RESULT (used only with the timeout feature)

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous, active-low reset
- soft_reset  in  1  synchronous reset from register block, active-high
- enable  in  1  level; permits starting new images
- s_axis_tvalid  in  1  pixel valid
- s_axis_tdata  in  DATAWIDTH  pixel
- s_axis_tready  out  1  pixel ready
- pix_valid  out  1  pixel strobe to layer 1
- pix_data  out  DATAWIDTH  pixel to layer 1
- result_valid  in  1  max-finder result strobe
- result_class  in  RESULT_WIDTH  max-finder result
- irq_clear  in  1  one-cycle pulse, clears irq
- irq  out  1  sticky completion/timeout interrupt
- busy  out  1  high in LOAD or WAIT_RESULT
- last_class  out  RESULT_WIDTH  last captured result
- image_count  out  COUNT_WIDTH  completed images, wraps
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, LOAD, WAIT_RESULT.
- IDLE: s_axis_tready=0. If enable=1, go to LOAD next cycle. pix_cnt=0.
- LOAD: s_axis_tready=1. Each beat with tvalid&tready increments pix_cnt. The beat with pix_cnt==NUM_PIXELS-1 moves to WAIT_RESULT and clears pix_cnt.
- Deasserting enable during LOAD has no effect. The current image always completes.
- WAIT_RESULT: s_axis_tready=0. result_valid captures result_class into last_class, increments image_count (wraps at 2^COUNT_WIDTH), sets irq, then goes to IDLE.
- result_valid in IDLE or LOAD: ignored. No capture, no count.
- irq: cleared by irq_clear. If set and clear happen in the same cycle, set wins.
- timeout_err: cleared only by reset or soft_reset.
- soft_reset: same effect as s_axi_aresetn, applied synchronously. It wins over all other events in its cycle, including mid-LOAD; any partial image is discarded.
- s_axis_tready depends only on registered state, with no combinational path from tvalid.

## Timing
- Reset values: s_axis_tready=0, pix_valid=0, pix_data=0, irq=0, busy=0, last_class=0, image_count=0, timeout_err=0; state=IDLE.
- pix_valid/pix_data are registered. A handshake in cycle N gives pix_valid=1 in cycle N+1, one strobe per beat, with gaps preserved.
- IDLE→LOAD: 1 cycle after enable is sampled high. tready rises in the first LOAD cycle.
- After the final pixel beat, tready=0 from the next cycle.
- A result_valid in cycle N gives last_class, image_count and irq updated in N+1, with state=IDLE in N+1. With enable high, LOAD resumes in N+2.
- busy is registered and equals (state != IDLE).

## Configuration
- INFER_TIMEOUT_EN:
  - Defined: a counter runs in WAIT_RESULT. When it reaches TIMEOUT_CYCLES without result_valid, timeout_err and irq are set and the state goes to IDLE. last_class and image_count are unchanged. The counter resets on entering WAIT_RESULT. If result_valid arrives in the same cycle the limit is reached, the result wins and no timeout is flagged.
  - Undefined: no counter is built, timeout_err is tied to 0, and WAIT_RESULT waits indefinitely.

## Structure
- Shared package nn_pkg holds:
  - state enum sched_state_t (IDLE, LOAD, WAIT_RESULT);
  - default constants NN_DATAWIDTH, NN_NUM_PIXELS, NN_RESULT_WIDTH.
- pix_cnt width is $clog2(NUM_PIXELS), computed locally.
- Single module, no sub-modules. The watchdog is a guarded counter inside the same module.

## Test plan
- Reset, then enable=1, then 784 back-to-back beats with tdata=i → 784 pix_valid strobes, pix_data 0..783 in order, each one cycle after its beat. tready=0 after the last beat; busy=1.
- In WAIT_RESULT, drive tvalid=1 plus result_valid with result_class=7 → no extra pix_valid. Next cycle: last_class=7, image_count=1, irq=1, busy=0. Pulse irq_clear → irq=0.
- Same-cycle irq_clear and result_valid (result_class=3) → irq stays 1, last_class=3.
- Random tvalid gaps, and enable dropped after 100 beats → all 784 pixels still accepted, then the block stays in IDLE with tready=0.
- soft_reset after 400 beats → all outputs at reset values the next cycle. A fresh image of 784 beats completes correctly.
- With INFER_TIMEOUT_EN and TIMEOUT_CYCLES=50, no result → timeout_err=1 and irq=1 at cycle 50 of WAIT_RESULT, image_count unchanged. A late result_valid is ignored. Without the macro, timeout_err stays 0.
